hazard_pipe_tracker: RTL and testbench
======================================

HAZARD_PIPE_TRACKER -- requirements
Module: hazard_pipe_tracker

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-specifier width.
REQ-002 SHALL have parameter CNT_W, default 16, bubble-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port hold, input, 1, global freeze (memory wait); all stages keep their values.
REQ-006 SHALL have port flush, input, 1, squash the instruction currently in ID.
REQ-007 SHALL have port stall_id, input, 1, load-use stall request from the hazard detector.
REQ-008 SHALL have port id_valid, input, 1, a real instruction is in ID.
REQ-009 SHALL have port id_rw, id_we and id_ld, inputs, REG_W/1/1, ID destination register, write-enable and is-load.
REQ-010 SHALL have port op_a_sel_id and op_b_sel_id, inputs, 2 each, forwarding selects decided in ID.
REQ-011 SHALL have port rw_id_ex, we_id_ex and ld_id_ex, outputs, REG_W/1/1, ID/EX destination tracking that feeds the hazard detector.
REQ-012 SHALL have port rw_ex_mem and we_ex_mem, outputs, REG_W/1, EX/MEM destination tracking that feeds the hazard detector.
REQ-013 SHALL have port rw_mem_wb and we_mem_wb, outputs, REG_W/1, MEM/WB destination (register-file write port).
REQ-014 SHALL have port op_a_sel_ex and op_b_sel_ex, outputs, 2 each, registered selects driving the EX operand muxes.
REQ-015 SHALL have port clr_count, input, 1, synchronous clear of bubble_count.
REQ-016 SHALL have port bubble_count, output, CNT_W, saturating count of inserted stall bubbles.

Function
REQ-017 SHALL define a bubble as rw=0, we=0, ld=0, both selects=NO_FWD.
REQ-018 SHALL, on a clock edge with hold=0, load ID/EX with a bubble if flush=1, else if stall_id=1, else if id_valid=0; otherwise it SHALL load the ID fields.
REQ-019 SHALL, when loading ID fields, force the captured we to 0 whenever id_rw==0 (no forwarding from R0); ld SHALL be captured only when we=1.
REQ-020 SHALL, on the same hold=0 edge, advance ID/EX{rw,we} to EX/MEM and EX/MEM{rw,we} to MEM/WB; latency is ID->EX 1 cycle, ->MEM 2 cycles, ->WB 3 cycles.
REQ-021 SHALL, with hold=1, keep every stage register and bubble_count unchanged; priority is hold > flush > stall_id > id_valid.
REQ-022 SHALL increment bubble_count on an edge with hold=0, stall_id=1, flush=0; it SHALL saturate at all-ones and never wrap.
REQ-023 SHALL give clr_count priority over increment and SHALL apply it regardless of hold; the next value is 0.
REQ-024 SHALL drive all outputs directly from registers, with no combinational input-to-output path.
REQ-025 SHALL, for a stall held N consecutive cycles, insert exactly N bubbles and count N.

Reset
REQ-026 SHALL, on rst_n=0, immediately clear all stage registers to bubble values and bubble_count to 0, including in mid-pipeline, with no pending state surviving.
REQ-027 SHALL, on rst_n deassertion, resume normal operation at the first following rising edge of clk.

Structure
REQ-028 SHALL take NO_FWD=2'b00, FWD_FROM_EX_MEM=2'b01 and FWD_FROM_MEM_WB=2'b10, and the SB/SH/SW opcode constants, from the shared processor package.
REQ-029 SHALL declare the bubble value and a stage-record struct {rw, we, ld} in that same package.
REQ-030 SHALL build each stage from one sub-module, pipe_stage_reg, with enable=~hold and sync load-bubble control; it is instantiated three times.

Verification
REQ-031 Issue id_rw=5, id_we=1, id_valid=1 for one cycle, then idle -> rw_id_ex=5 at +1, rw_ex_mem=5 at +2, rw_mem_wb=5 at +3, with we following each.
REQ-032 Issue id_rw=0, id_we=1 -> we_id_ex=0 and ld_id_ex=0 at +1.
REQ-033 Hold stall_id=1 for 2 cycles with a load (rw=8, ld=1) already in ID/EX -> 2 bubbles in ID/EX, load reaches EX/MEM, bubble_count=2.
REQ-034 Assert hold=1 for 3 cycles with stall_id=1 -> all outputs frozen and bubble_count unchanged; flush+stall together -> bubble inserted and count not incremented.
REQ-035 Preload bubble_count=0xFFFE, then stall 3 cycles -> 0xFFFF, stays 0xFFFF; clr_count with stall_id=1 -> 0.
REQ-036 Drop rst_n mid-cycle with all stages valid -> all we outputs and bubble_count are 0 before the next edge.

Source files
------------

// File: rtl/hazard_pipe_tracker_pkg.sv
// rtl/hazard_pipe_tracker_pkg.sv - shared processor constants and stage record types
package hazard_pipe_tracker_pkg;

    // Forwarding select encodings for the EX operand muxes
    localparam logic [1:0] NO_FWD          = 2'b00;
    localparam logic [1:0] FWD_FROM_EX_MEM = 2'b01;
    localparam logic [1:0] FWD_FROM_MEM_WB = 2'b10;

    // Store-width funct3 codes
    localparam logic [2:0] SB = 3'b000;
    localparam logic [2:0] SH = 3'b001;
    localparam logic [2:0] SW = 3'b010;

    // Register-specifier width of the reference core
    localparam int PKG_REG_W = 5;

    // Destination-tracking record carried down the pipe
    typedef struct packed {
        logic [PKG_REG_W-1:0] rw;
        logic                 we;
        logic                 ld;
    } stage_t;

    // A bubble writes nothing and loads nothing
    localparam stage_t BUBBLE_STAGE = '{rw: '0, we: 1'b0, ld: 1'b0};

endpackage

// File: rtl/hazard_pipe_tracker_stage_reg.sv
// rtl/hazard_pipe_tracker_stage_reg.sv - one pipeline stage register with enable and bubble load
module pipe_stage_reg #(
    parameter int           W      = 8,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load_bubble,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] stage_q;
    logic [W-1:0] stage_d;

    // Next value: freeze when disabled, otherwise capture a bubble or the incoming data
    always_comb begin
        stage_d = stage_q;
        if (en) begin
            stage_d = load_bubble ? BUBBLE : d;
        end
    end

    // Stage storage, cleared to a bubble on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/hazard_pipe_tracker.sv
// rtl/hazard_pipe_tracker.sv - destination/forwarding tracking through ID/EX, EX/MEM, MEM/WB
module hazard_pipe_tracker
    import hazard_pipe_tracker_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             flush,
    input  logic             stall_id,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rw,
    input  logic             id_we,
    input  logic             id_ld,
    input  logic [1:0]       op_a_sel_id,
    input  logic [1:0]       op_b_sel_id,
    output logic [REG_W-1:0] rw_id_ex,
    output logic             we_id_ex,
    output logic             ld_id_ex,
    output logic [REG_W-1:0] rw_ex_mem,
    output logic             we_ex_mem,
    output logic [REG_W-1:0] rw_mem_wb,
    output logic             we_mem_wb,
    output logic [1:0]       op_a_sel_ex,
    output logic [1:0]       op_b_sel_ex,
    input  logic             clr_count,
    output logic [CNT_W-1:0] bubble_count
);

    localparam int IDEX_W = REG_W + 6;
    localparam int DST_W  = REG_W + 1;
    localparam logic [IDEX_W-1:0] IDEX_BUBBLE = {{(REG_W + 2){1'b0}}, NO_FWD, NO_FWD};

    logic              en;
    logic              id_bubble;
    logic              we_cap;
    logic              ld_cap;
    logic [IDEX_W-1:0] id_ex_d;
    logic [IDEX_W-1:0] id_ex_q;
    logic [DST_W-1:0]  ex_mem_q;
    logic [DST_W-1:0]  mem_wb_q;
    logic [CNT_W-1:0]  bubble_count_q;
    logic [CNT_W-1:0]  bubble_count_d;

    assign en        = ~hold;
    assign id_bubble = flush | stall_id | ~id_valid;

    // R0 never forwards, and a load only matters if it writes
    always_comb begin
        we_cap  = id_we & (id_rw != '0);
        ld_cap  = id_ld & we_cap;
        id_ex_d = {id_rw, we_cap, ld_cap, op_a_sel_id, op_b_sel_id};
    end

    pipe_stage_reg #(.W(IDEX_W), .BUBBLE(IDEX_BUBBLE)) u_id_ex (
        .clk(clk), .rst_n(rst_n), .en(en), .load_bubble(id_bubble),
        .d(id_ex_d), .q(id_ex_q)
    );

    pipe_stage_reg #(.W(DST_W), .BUBBLE('0)) u_ex_mem (
        .clk(clk), .rst_n(rst_n), .en(en), .load_bubble(1'b0),
        .d(id_ex_q[IDEX_W-1 -: DST_W]), .q(ex_mem_q)
    );

    pipe_stage_reg #(.W(DST_W), .BUBBLE('0)) u_mem_wb (
        .clk(clk), .rst_n(rst_n), .en(en), .load_bubble(1'b0),
        .d(ex_mem_q), .q(mem_wb_q)
    );

    // Bubble counter: clear wins even under hold, increments saturate at all-ones
    always_comb begin
        bubble_count_d = bubble_count_q;
        if (clr_count) begin
            bubble_count_d = '0;
        end else if (!hold && stall_id && !flush && (bubble_count_q != '1)) begin
            bubble_count_d = bubble_count_q + 1'b1;
        end
    end

    // Bubble counter storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_count_q <= '0;
        end else begin
            bubble_count_q <= bubble_count_d;
        end
    end

    assign {rw_id_ex, we_id_ex, ld_id_ex, op_a_sel_ex, op_b_sel_ex} = id_ex_q;
    assign {rw_ex_mem, we_ex_mem} = ex_mem_q;
    assign {rw_mem_wb, we_mem_wb} = mem_wb_q;
    assign bubble_count = bubble_count_q;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// tb/tb_hazard_pipe_tracker.sv - directed self-checking bench for hazard_pipe_tracker
module tb_hazard_pipe_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold, flush, stall_id, id_valid, id_we, id_ld, clr_count;
    logic [4:0]  id_rw;
    logic [1:0]  op_a_sel_id, op_b_sel_id;
    logic [4:0]  rw_id_ex, rw_ex_mem, rw_mem_wb;
    logic        we_id_ex, ld_id_ex, we_ex_mem, we_mem_wb;
    logic [1:0]  op_a_sel_ex, op_b_sel_ex;
    logic [15:0] bubble_count;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    hazard_pipe_tracker #(.REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .stall_id(stall_id),
        .id_valid(id_valid), .id_rw(id_rw), .id_we(id_we), .id_ld(id_ld),
        .op_a_sel_id(op_a_sel_id), .op_b_sel_id(op_b_sel_id),
        .rw_id_ex(rw_id_ex), .we_id_ex(we_id_ex), .ld_id_ex(ld_id_ex),
        .rw_ex_mem(rw_ex_mem), .we_ex_mem(we_ex_mem),
        .rw_mem_wb(rw_mem_wb), .we_mem_wb(we_mem_wb),
        .op_a_sel_ex(op_a_sel_ex), .op_b_sel_ex(op_b_sel_ex),
        .clr_count(clr_count), .bubble_count(bubble_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] rw, input logic we, input logic ld);
        id_valid = 1'b1;
        id_rw    = rw;
        id_we    = we;
        id_ld    = ld;
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; flush = 1'b0; stall_id = 1'b0; id_valid = 1'b0;
        id_rw = '0; id_we = 1'b0; id_ld = 1'b0; clr_count = 1'b0;
        op_a_sel_id = 2'b00; op_b_sel_id = 2'b00;
        #12;
        chk("reset_we_all", 32'({we_id_ex, we_ex_mem, we_mem_wb}), 32'h0);
        chk("reset_rw_all", 32'({rw_id_ex, rw_ex_mem, rw_mem_wb}), 32'h0);
        chk("reset_count", 32'(bubble_count), 32'h0);
        rst_n = 1'b1;
        step();

        // Single instruction walks down the pipe
        issue(5'd5, 1'b1, 1'b0);
        op_a_sel_id = 2'b01; op_b_sel_id = 2'b10;
        step();
        chk("p1_id_ex", 32'({rw_id_ex, we_id_ex}), 32'h0B);
        chk("p1_sel", 32'({op_a_sel_ex, op_b_sel_ex}), 32'h6);
        id_valid = 1'b0; op_a_sel_id = 2'b00; op_b_sel_id = 2'b00;
        step();
        chk("p2_ex_mem", 32'({rw_ex_mem, we_ex_mem}), 32'h0B);
        chk("p2_id_ex_idle", 32'({rw_id_ex, we_id_ex, op_a_sel_ex, op_b_sel_ex}), 32'h0);
        step();
        chk("p3_mem_wb", 32'({rw_mem_wb, we_mem_wb}), 32'h0B);

        // Writes to R0 never enable forwarding
        issue(5'd0, 1'b1, 1'b1);
        step();
        chk("r0_we_ld", 32'({we_id_ex, ld_id_ex}), 32'h0);

        // Load followed by a two-cycle load-use stall
        issue(5'd8, 1'b1, 1'b1);
        step();
        chk("ld_in_id_ex", 32'({rw_id_ex, we_id_ex, ld_id_ex}), 32'h23);
        issue(5'd9, 1'b1, 1'b0);
        stall_id = 1'b1;
        step();
        chk("stall1_bubble", 32'({rw_id_ex, we_id_ex, ld_id_ex}), 32'h0);
        chk("stall1_ex_mem", 32'({rw_ex_mem, we_ex_mem}), 32'h11);
        step();
        chk("stall2_bubble", 32'({rw_id_ex, we_id_ex}), 32'h0);
        chk("stall2_count", 32'(bubble_count), 32'd2);
        chk("stall2_mem_wb", 32'({rw_mem_wb, we_mem_wb}), 32'h11);

        // Hold freezes everything, even with a stall and a new instruction pending
        hold = 1'b1;
        issue(5'd3, 1'b1, 1'b0);
        repeat (3) step();
        chk("hold_mem_wb", 32'({rw_mem_wb, we_mem_wb}), 32'h11);
        chk("hold_id_ex", 32'({rw_id_ex, we_id_ex}), 32'h0);
        chk("hold_count", 32'(bubble_count), 32'd2);

        // Flush with stall inserts a bubble but does not count
        hold = 1'b0; flush = 1'b1;
        step();
        chk("flush_bubble", 32'({rw_id_ex, we_id_ex}), 32'h0);
        chk("flush_count", 32'(bubble_count), 32'd2);
        chk("flush_mem_wb_adv", 32'({rw_mem_wb, we_mem_wb}), 32'h0);
        flush = 1'b0; stall_id = 1'b0; id_valid = 1'b0;

        // Clear applies under hold
        hold = 1'b1; clr_count = 1'b1;
        step();
        chk("clr_under_hold", 32'(bubble_count), 32'd0);
        hold = 1'b0; clr_count = 1'b0;

        // Saturation
        stall_id = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        chk("preload_fffe", 32'(bubble_count), 32'hFFFE);
        step();
        chk("sat_ffff", 32'(bubble_count), 32'hFFFF);
        step(); step();
        chk("sat_hold_ffff", 32'(bubble_count), 32'hFFFF);
        clr_count = 1'b1;
        step();
        chk("clr_over_stall", 32'(bubble_count), 32'd0);
        clr_count = 1'b0;
        step();
        chk("count_after_clr", 32'(bubble_count), 32'd1);
        stall_id = 1'b0;

        // Fill pipe, then reset mid-cycle
        issue(5'd1, 1'b1, 1'b0); step();
        issue(5'd2, 1'b1, 1'b0); step();
        issue(5'd3, 1'b1, 1'b1); step();
        chk("full_we", 32'({we_id_ex, we_ex_mem, we_mem_wb}), 32'h7);
        chk("full_rw", 32'({rw_id_ex, rw_ex_mem, rw_mem_wb}), 32'({5'd3, 5'd2, 5'd1}));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", 32'({we_id_ex, we_ex_mem, we_mem_wb, ld_id_ex}), 32'h0);
        chk("async_rst_count", 32'(bubble_count), 32'd0);
        #1;
        rst_n = 1'b1;
        issue(5'd7, 1'b1, 1'b0);
        step();
        chk("resume_id_ex", 32'({rw_id_ex, we_id_ex}), 32'h0F);
        chk("resume_ex_mem", 32'({rw_ex_mem, we_ex_mem}), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
